rr_quantum_timer: RTL and testbench

- Round-robin time-slice engine directly downstream of the environment-variables stage.
- Consumes the timer-enable, kernel-swap clear, input-block and PID controls, and produces the active PID that drives paging/memory selection.
- Counts the quantum of the running user process. On expiry it pre-empts by forcing the active PID to the kernel PID and pulses a pre-emption flag, handing control to the scheduler.

---
 rtl/rr_quantum_timer.sv | 129 ++++++++++++
 tb/tb_rr_quantum_timer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_quantum_timer.sv
// Round-robin time-slice engine.
// Tracks the quantum of the running user process and drives the active PID.
// When the slice runs out it forces the kernel PID, pulses preempt for one
// cycle and then waits in EXPIRED until the kernel swap clears it.
module rr_quantum_timer #(
    parameter int QUANTUM    = 64,
    parameter int CW         = 8,
    parameter int PID_W      = 5,
    parameter int KERNEL_PID = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kswap_clr,
    input  logic             timer_en,
    input  logic             block,
    input  logic [PID_W-1:0] pid_in,
    output logic [PID_W-1:0] pid_out,
    output logic             preempt,
    output logic             expired,
    output logic             running,
    output logic [CW-1:0]    count
);

    // The last counted cycle of a slice; the next RUN edge after this expires.
    localparam logic [CW-1:0]    LAST_COUNT = CW'(QUANTUM - 1);
    localparam logic [PID_W-1:0] KPID       = PID_W'(KERNEL_PID);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t state_reg;

    // Is the requested PID the kernel? The kernel is never time-sliced.
    logic pid_is_kernel;
    assign pid_is_kernel = (pid_in == KPID);

    // Slice FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            pid_out   <= KPID;
            count     <= '0;
            preempt   <= 1'b0;
            expired   <= 1'b0;
            running   <= 1'b0;
        end else begin
            // preempt is a single-cycle pulse unless the expiry branch sets it.
            preempt <= 1'b0;
            if (kswap_clr) begin
                // Kernel swap wins over everything, including a set-PID.
                state_reg <= IDLE;
                pid_out   <= KPID;
                count     <= '0;
                expired   <= 1'b0;
                running   <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (timer_en) begin
                            pid_out <= pid_in;
                            count   <= '0;
                            if (pid_is_kernel) begin
                                state_reg <= IDLE;
                                running   <= 1'b0;
                            end else if (block) begin
                                state_reg <= HOLD;
                                running   <= 1'b1;
                            end else begin
                                state_reg <= RUN;
                                running   <= 1'b1;
                            end
                        end
                    end
                    RUN, HOLD: begin
                        if (timer_en) begin
                            // Re-issued set-PID restarts the slice from zero.
                            pid_out <= pid_in;
                            count   <= '0;
                            if (pid_is_kernel) begin
                                state_reg <= IDLE;
                                running   <= 1'b0;
                            end else if (block) begin
                                state_reg <= HOLD;
                                running   <= 1'b1;
                            end else begin
                                state_reg <= RUN;
                                running   <= 1'b1;
                            end
                        end else if (block) begin
                            // Blocking input: freeze the quantum where it is.
                            state_reg <= HOLD;
                        end else if (state_reg == HOLD) begin
                            // Leaving HOLD costs no count; counting resumes next cycle.
                            state_reg <= RUN;
                        end else if (count == LAST_COUNT) begin
                            state_reg <= EXPIRED;
                            pid_out   <= KPID;
                            count     <= '0;
                            preempt   <= 1'b1;
                            expired   <= 1'b1;
                            running   <= 1'b0;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    EXPIRED: begin
                        // Parked on the kernel PID until kswap_clr or reset.
                        state_reg <= EXPIRED;
                        pid_out   <= KPID;
                        expired   <= 1'b1;
                        running   <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        pid_out   <= KPID;
                        count     <= '0;
                        expired   <= 1'b0;
                        running   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rr_quantum_timer.sv
// Directed bench for rr_quantum_timer with QUANTUM=4.
// Observed vector layout: {pid_out[4:0], count[7:0], preempt, expired, running}.
module tb_rr_quantum_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       kswap_clr = 1'b0;
    logic       timer_en = 1'b0;
    logic       block = 1'b0;
    logic [4:0] pid_in = 5'd0;
    logic [4:0] pid_out;
    logic       preempt;
    logic       expired;
    logic       running;
    logic [7:0] count;

    int checks = 0;
    int errors = 0;

    logic [15:0] obs;
    assign obs = {pid_out, count, preempt, expired, running};

    rr_quantum_timer #(
        .QUANTUM   (4),
        .CW        (8),
        .PID_W     (5),
        .KERNEL_PID(0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .kswap_clr(kswap_clr),
        .timer_en (timer_en),
        .block    (block),
        .pid_in   (pid_in),
        .pid_out  (pid_out),
        .preempt  (preempt),
        .expired  (expired),
        .running  (running),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] exp_v;
        reset = 1'b0; timer_en = 1'b1; pid_in = 5'd7;
        tick(); tick();
        exp_v = {5'd0, 8'd0, 3'b000};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", obs, exp_v);
        end else $display("reset_hold: obs=%h ok", obs);
        reset = 1'b1; timer_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_release_%0d: got %h want %h", i, obs, exp_v);
            end else $display("reset_release_%0d: obs=%h ok", i, obs);
        end
    endtask

    task automatic test_normal_slice();
        logic [15:0] exp_v;
        timer_en = 1'b1; pid_in = 5'd3;
        tick();
        timer_en = 1'b0;
        exp_v = {5'd3, 8'd0, 3'b001};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL normal_start: got %h want %h", obs, exp_v);
        end else $display("normal_start: obs=%h ok", obs);
        for (int c = 1; c <= 3; c++) begin
            tick();
            exp_v = {5'd3, 8'(c), 3'b001};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL normal_count_%0d: got %h want %h", c, obs, exp_v);
            end else $display("normal_count_%0d: obs=%h ok", c, obs);
        end
        tick();
        exp_v = {5'd0, 8'd0, 3'b110};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL normal_expiry: got %h want %h", obs, exp_v);
        end else $display("normal_expiry: obs=%h ok", obs);
        tick();
        exp_v = {5'd0, 8'd0, 3'b010};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL normal_pulse_end: got %h want %h", obs, exp_v);
        end else $display("normal_pulse_end: obs=%h ok", obs);
        // EXPIRED ignores timer_en and block.
        timer_en = 1'b1; block = 1'b1; pid_in = 5'd5;
        tick();
        timer_en = 1'b0; block = 1'b0;
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL expired_ignores: got %h want %h", obs, exp_v);
        end else $display("expired_ignores: obs=%h ok", obs);
    endtask

    task automatic test_kswap();
        logic [15:0] exp_v;
        kswap_clr = 1'b1; timer_en = 1'b1; pid_in = 5'd4;
        tick();
        kswap_clr = 1'b0;
        exp_v = {5'd0, 8'd0, 3'b000};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL kswap_clear: got %h want %h", obs, exp_v);
        end else $display("kswap_clear: obs=%h ok", obs);
        tick();
        timer_en = 1'b0;
        exp_v = {5'd4, 8'd0, 3'b001};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL kswap_then_start: got %h want %h", obs, exp_v);
        end else $display("kswap_then_start: obs=%h ok", obs);
    endtask

    task automatic test_kernel_reload();
        logic [15:0] exp_v;
        kswap_clr = 1'b1;
        tick();
        kswap_clr = 1'b0;
        timer_en = 1'b1; pid_in = 5'd0;
        tick();
        timer_en = 1'b0;
        exp_v = {5'd0, 8'd0, 3'b000};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL kernel_pid_idle: got %h want %h", obs, exp_v);
        end else $display("kernel_pid_idle: obs=%h ok", obs);
        timer_en = 1'b1; pid_in = 5'd2;
        tick();
        timer_en = 1'b0;
        tick(); tick(); tick();
        exp_v = {5'd2, 8'd3, 3'b001};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reload_pre: got %h want %h", obs, exp_v);
        end else $display("reload_pre: obs=%h ok", obs);
        timer_en = 1'b1; pid_in = 5'd6;
        tick();
        timer_en = 1'b0;
        exp_v = {5'd6, 8'd0, 3'b001};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reload_at_last: got %h want %h", obs, exp_v);
        end else $display("reload_at_last: obs=%h ok", obs);
        tick();
        exp_v = {5'd6, 8'd1, 3'b001};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reload_counts: got %h want %h", obs, exp_v);
        end else $display("reload_counts: obs=%h ok", obs);
        timer_en = 1'b1; pid_in = 5'd0;
        tick();
        timer_en = 1'b0;
        exp_v = {5'd0, 8'd0, 3'b000};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reload_kernel_idle: got %h want %h", obs, exp_v);
        end else $display("reload_kernel_idle: obs=%h ok", obs);
    endtask

    task automatic test_block_freeze();
        logic [15:0] exp_v;
        timer_en = 1'b1; pid_in = 5'd9;
        tick();
        timer_en = 1'b0;
        tick(); tick();
        exp_v = {5'd9, 8'd2, 3'b001};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL block_pre: got %h want %h", obs, exp_v);
        end else $display("block_pre: obs=%h ok", obs);
        block = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL block_hold_%0d: got %h want %h", i, obs, exp_v);
            end else $display("block_hold_%0d: obs=%h ok", i, obs);
        end
        block = 1'b0;
        tick();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL block_resume: got %h want %h", obs, exp_v);
        end else $display("block_resume: obs=%h ok", obs);
        tick();
        exp_v = {5'd9, 8'd3, 3'b001};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL block_count3: got %h want %h", obs, exp_v);
        end else $display("block_count3: obs=%h ok", obs);
        tick();
        exp_v = {5'd0, 8'd0, 3'b110};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL block_expiry: got %h want %h", obs, exp_v);
        end else $display("block_expiry: obs=%h ok", obs);
        kswap_clr = 1'b1;
        tick();
        kswap_clr = 1'b0;
        // Start directly into HOLD: block together with set-PID.
        timer_en = 1'b1; block = 1'b1; pid_in = 5'd11;
        tick();
        timer_en = 1'b0;
        tick();
        block = 1'b0;
        exp_v = {5'd11, 8'd0, 3'b001};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL idle_to_hold: got %h want %h", obs, exp_v);
        end else $display("idle_to_hold: obs=%h ok", obs);
        kswap_clr = 1'b1;
        tick();
        kswap_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [15:0] exp_v;
        timer_en = 1'b1; pid_in = 5'd5;
        tick();
        timer_en = 1'b0;
        tick(); tick();
        exp_v = {5'd5, 8'd2, 3'b001};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_pre: got %h want %h", obs, exp_v);
        end else $display("async_pre: obs=%h ok", obs);
        #2;
        reset = 1'b0;
        #1;
        exp_v = {5'd0, 8'd0, 3'b000};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_clear: got %h want %h", obs, exp_v);
        end else $display("async_clear: obs=%h ok", obs);
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_after: got %h want %h", obs, exp_v);
        end else $display("async_after: obs=%h ok", obs);
    endtask

    initial begin
        test_reset();
        test_normal_slice();
        test_kswap();
        test_kernel_reload();
        test_block_freeze();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
